// File: rtl/cgia_pkg.sv
// Shared types and default timing for the scanline line-buffer scheduler.
package cgia_pkg;

  // Progress of the fill of the write bank during one scanline
  typedef enum logic [1:0] {
    FS_IDLE,
    FS_REQ,
    FS_FILL,
    FS_DONE
  } fill_state_e;

  // Default horizontal timing in dot clocks
  localparam int DEF_H_TOTAL  = 800;
  localparam int DEF_H_ACTIVE = 512;
  localparam int DEF_HS_START = 528;
  localparam int DEF_HS_END   = 592;

  // Default number of words written into a bank per line fill
  localparam int DEF_FILL_LEN = 512;

  // Width of the line buffer write address
  localparam int ADR_W = 9;

endpackage

// File: rtl/htimer.sv
// Horizontal dot counter: produces feeder enable, hsync, line start and the
// swap event that marks the last dot of every scanline.
module htimer
  import cgia_pkg::*;
#(
  parameter int H_TOTAL  = DEF_H_TOTAL,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int HS_START = DEF_HS_START,
  parameter int HS_END   = DEF_HS_END
) (
  input  logic dotclk_i,
  input  logic rst_ni,
  output logic swap_o,
  output logic scanline_en_o,
  output logic hsync_o,
  output logic line_start_o
);

  localparam int HW = $clog2(H_TOTAL);
  localparam logic [HW-1:0] LAST_CNT = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] ACT_END  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_FIRST = HW'(HS_START);
  localparam logic [HW-1:0] HS_AFTER = HW'(HS_END);

  logic [HW-1:0] hcount_q;
  logic [HW-1:0] hcount_d;
  logic          scanline_en_q;
  logic          hsync_q;
  logic          line_start_q;

  // The swap event is the last dot of the line, seen directly on the counter
  assign swap_o = (hcount_q == LAST_CNT);

  // Next dot position, wrapping at the end of the line
  always_comb begin
    hcount_d = swap_o ? '0 : hcount_q + 1'b1;
  end

  // Counter and registered timing strobes decoded from the current dot
  always_ff @(posedge dotclk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hcount_q      <= '0;
      scanline_en_q <= 1'b0;
      hsync_q       <= 1'b0;
      line_start_q  <= 1'b0;
    end else begin
      hcount_q      <= hcount_d;
      scanline_en_q <= (hcount_q < ACT_END);
      hsync_q       <= (hcount_q >= HS_FIRST) && (hcount_q < HS_AFTER);
      line_start_q  <= swap_o;
    end
  end

  assign scanline_en_o = scanline_en_q;
  assign hsync_o       = hsync_q;
  assign line_start_o  = line_start_q;

endmodule

// File: rtl/linebuf_sched.sv
// Double-buffered line buffer scheduler: requests a fill of the write bank
// each displayed line and swaps banks at the end of the line only if the
// fill finished; an unfinished fill is aborted and flagged as underrun.
module linebuf_sched
  import cgia_pkg::*;
#(
  parameter int H_TOTAL  = DEF_H_TOTAL,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int HS_START = DEF_HS_START,
  parameter int HS_END   = DEF_HS_END,
  parameter int FILL_LEN = DEF_FILL_LEN
) (
  input  logic             dotclk_i,
  input  logic             rst_ni,
  input  logic             line_en_i,
  input  logic             ack_i,
  input  logic             wr_stb_i,
  input  logic             clr_i,
  output logic             scanline_en_o,
  output logic             hsync_o,
  output logic             line_start_o,
  output logic             req_o,
  output logic             abort_o,
  output logic [ADR_W-1:0] w_adr_o,
  output logic             w_bank_o,
  output logic             r_bank_o,
  output logic             underrun_o
);

  localparam logic [ADR_W-1:0] LAST_ADR = ADR_W'(FILL_LEN - 1);

  fill_state_e      state_q;
  fill_state_e      state_d;
  logic [ADR_W-1:0] w_adr_q;
  logic [ADR_W-1:0] w_adr_d;
  logic             req_q;
  logic             req_d;
  logic             abort_q;
  logic             abort_d;
  logic             underrun_q;
  logic             underrun_d;
  logic             w_bank_q;
  logic             w_bank_d;
  logic             r_bank_q;
  logic             r_bank_d;

  logic swap;
  logic last_stb;
  logic toggle;
  logic abort_ev;
  logic ur_set;

  htimer #(
    .H_TOTAL (H_TOTAL),
    .H_ACTIVE(H_ACTIVE),
    .HS_START(HS_START),
    .HS_END  (HS_END)
  ) u_htimer (
    .dotclk_i     (dotclk_i),
    .rst_ni       (rst_ni),
    .swap_o       (swap),
    .scanline_en_o(scanline_en_o),
    .hsync_o      (hsync_o),
    .line_start_o (line_start_o)
  );

  // Fill state register
  always_ff @(posedge dotclk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= FS_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next fill state and write address; the swap event overrides ack/strobe
  always_comb begin
    state_d  = state_q;
    w_adr_d  = w_adr_q;
    toggle   = 1'b0;
    abort_ev = 1'b0;
    ur_set   = 1'b0;
    last_stb = (state_q == FS_FILL) && wr_stb_i && (w_adr_q == LAST_ADR);
    if (swap) begin
      w_adr_d = '0;
      state_d = line_en_i ? FS_REQ : FS_IDLE;
      if ((state_q == FS_DONE) || last_stb) begin
        toggle = 1'b1;
      end else if ((state_q == FS_REQ) || (state_q == FS_FILL)) begin
        abort_ev = 1'b1;
        ur_set   = line_en_i;
      end
    end else begin
      case (state_q)
        FS_REQ: begin
          if (ack_i) begin
            state_d = FS_FILL;
            w_adr_d = '0;
          end
        end
        FS_FILL: begin
          if (wr_stb_i) begin
            w_adr_d = w_adr_q + 1'b1;
            if (last_stb) begin
              state_d = FS_DONE;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Next values of the registered outputs; an underrun set beats a clear
  always_comb begin
    req_d      = (state_d == FS_REQ);
    abort_d    = abort_ev;
    underrun_d = ur_set ? 1'b1 : (clr_i ? 1'b0 : underrun_q);
    w_bank_d   = toggle ? ~w_bank_q : w_bank_q;
    r_bank_d   = toggle ? ~r_bank_q : r_bank_q;
  end

  // Output and datapath registers
  always_ff @(posedge dotclk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      w_adr_q    <= '0;
      req_q      <= 1'b0;
      abort_q    <= 1'b0;
      underrun_q <= 1'b0;
      w_bank_q   <= 1'b1;
      r_bank_q   <= 1'b0;
    end else begin
      w_adr_q    <= w_adr_d;
      req_q      <= req_d;
      abort_q    <= abort_d;
      underrun_q <= underrun_d;
      w_bank_q   <= w_bank_d;
      r_bank_q   <= r_bank_d;
    end
  end

  assign req_o      = req_q;
  assign abort_o    = abort_q;
  assign underrun_o = underrun_q;
  assign w_adr_o    = w_adr_q;
  assign w_bank_o   = w_bank_q;
  assign r_bank_o   = r_bank_q;

endmodule

// File: tb/tb_linebuf_sched.sv
// Scoreboard bench for linebuf_sched: a line-level reference model predicts
// the outputs after every clock edge, a monitor compares them on the falling edge.
module tb_linebuf_sched;

  localparam int H_TOTAL  = 16;
  localparam int H_ACTIVE = 8;
  localparam int HS_START = 10;
  localparam int HS_END   = 12;
  localparam int FILL_LEN = 8;

  typedef struct {
    bit       scan;
    bit       hs;
    bit       ls;
    bit       req;
    bit       abort;
    bit [8:0] adr;
    bit       wb;
    bit       rb;
    bit       ur;
  } exp_t;

  logic       dotclk = 1'b0;
  logic       rstN = 1'b1;
  logic       lineEn = 1'b0;
  logic       ack = 1'b0;
  logic       wrStb = 1'b0;
  logic       clr = 1'b0;
  logic       scanlineEn;
  logic       hsync;
  logic       lineStart;
  logic       req;
  logic       abortP;
  logic [8:0] wAdr;
  logic       wBank;
  logic       rBank;
  logic       underrun;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: position in the line and progress of the current line's fill
  int mHc;
  bit mFillWanted;
  bit mAccepted;
  int mWords;
  bit mUnderrun;
  bit mWBank;

  linebuf_sched #(
    .H_TOTAL (H_TOTAL),
    .H_ACTIVE(H_ACTIVE),
    .HS_START(HS_START),
    .HS_END  (HS_END),
    .FILL_LEN(FILL_LEN)
  ) dut (
    .dotclk_i     (dotclk),
    .rst_ni       (rstN),
    .line_en_i    (lineEn),
    .ack_i        (ack),
    .wr_stb_i     (wrStb),
    .clr_i        (clr),
    .scanline_en_o(scanlineEn),
    .hsync_o      (hsync),
    .line_start_o (lineStart),
    .req_o        (req),
    .abort_o      (abortP),
    .w_adr_o      (wAdr),
    .w_bank_o     (wBank),
    .r_bank_o     (rBank),
    .underrun_o   (underrun)
  );

  // Dot clock
  always #5 dotclk = ~dotclk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    mHc         = 0;
    mFillWanted = 1'b0;
    mAccepted   = 1'b0;
    mWords      = 0;
    mUnderrun   = 1'b0;
    mWBank      = 1'b1;
  endtask

  // Advance the model by one dot with the inputs that were present at the edge
  task automatic modelEdge(input bit le, input bit ak, input bit st, input bit cl);
    exp_t e;
    bit   swap;
    bit   complete;
    bit   urSet;
    swap   = (mHc == H_TOTAL - 1);
    e.scan = (mHc < H_ACTIVE);
    e.hs   = (mHc >= HS_START) && (mHc < HS_END);
    e.ls   = swap;
    mHc    = (mHc + 1) % H_TOTAL;
    e.abort = 1'b0;
    urSet   = 1'b0;
    if (mAccepted && (mWords < FILL_LEN) && st) mWords++;
    complete = mAccepted && (mWords == FILL_LEN);
    if (swap) begin
      if (complete) begin
        mWBank = !mWBank;
      end else if (mFillWanted) begin
        e.abort = 1'b1;
        urSet   = le;
      end
      mFillWanted = le;
      mAccepted   = 1'b0;
      mWords      = 0;
    end else if (mFillWanted && !mAccepted && ak) begin
      mAccepted = 1'b1;
      mWords    = 0;
    end
    if (urSet) mUnderrun = 1'b1;
    else if (cl) mUnderrun = 1'b0;
    e.req = mFillWanted && !mAccepted;
    e.adr = 9'(mWords % 512);
    e.wb  = mWBank;
    e.rb  = !mWBank;
    e.ur  = mUnderrun;
    expQ.push_back(e);
  endtask

  // Drive one cycle of inputs, then record the model's prediction for that edge
  task automatic applyStimulus(input bit le, input bit ak, input bit st, input bit cl);
    lineEn = le;
    ack    = ak;
    wrStb  = st;
    clr    = cl;
    @(posedge dotclk);
    modelEdge(le, ak, st, cl);
    #1;
  endtask

  task automatic idleUntilHc(input int target, input bit le);
    for (int i = 0; i < H_TOTAL && mHc != target; i++) applyStimulus(le, 1'b0, 1'b0, 1'b0);
  endtask

  // Asynchronous reset between edges; outputs must take reset values at once
  task automatic doReset();
    @(negedge dotclk);
    #1;
    rstN = 1'b0;
    #1;
    checkOutput("reset scanline_en", scanlineEn, 0);
    checkOutput("reset hsync", hsync, 0);
    checkOutput("reset line_start", lineStart, 0);
    checkOutput("reset req", req, 0);
    checkOutput("reset abort", abortP, 0);
    checkOutput("reset w_adr", wAdr, 0);
    checkOutput("reset w_bank", wBank, 1);
    checkOutput("reset r_bank", rBank, 0);
    checkOutput("reset underrun", underrun, 0);
    modelReset();
    lineEn = 1'b0;
    ack    = 1'b0;
    wrStb  = 1'b0;
    clr    = 1'b0;
    @(negedge dotclk);
    #1;
    rstN = 1'b1;
  endtask

  // Monitor: compare DUT outputs with the oldest prediction
  always @(negedge dotclk) begin
    exp_t e;
    if (rstN && expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput("scanline_en", scanlineEn, e.scan);
      checkOutput("hsync", hsync, e.hs);
      checkOutput("line_start", lineStart, e.ls);
      checkOutput("req", req, e.req);
      checkOutput("abort", abortP, e.abort);
      checkOutput("w_adr", wAdr, e.adr);
      checkOutput("w_bank", wBank, e.wb);
      checkOutput("r_bank", rBank, e.rb);
      checkOutput("underrun", underrun, e.ur);
    end
  end

  initial begin
    modelReset();
    doReset();

    // Free run on displayed lines with no fetcher: aborts and underrun
    repeat (3 * H_TOTAL) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);

    // Complete fill well before the end of the line
    idleUntilHc(0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (FILL_LEN) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    idleUntilHc(1, 1'b1);

    // Last strobe lands exactly on the swap cycle
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    idleUntilHc(H_TOTAL - FILL_LEN, 1'b1);
    repeat (FILL_LEN) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);

    // Short fill: underrun, then clear it
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (5) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    idleUntilHc(1, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);

    // Reset in the middle of a fill at write address 3
    idleUntilHc(0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    doReset();

    // First request after reset at the first swap, then line disabled mid-fill
    repeat (H_TOTAL) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (2) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    idleUntilHc(H_TOTAL - 1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (H_TOTAL + 2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 1200; i++) begin
      applyStimulus($urandom_range(0, 9) != 0, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 9) < 8, $urandom_range(0, 19) == 0);
    end

    @(negedge dotclk);
    #1;
    checkOutput("scoreboard drained", expQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/linebuf_sched.md
LINEBUF_SCHED -- requirements
Module: linebuf_sched

Interface
REQ-001 Parameter H_TOTAL, default 800; dot clocks per scanline.
REQ-002 Parameter H_ACTIVE, default 512; active dots per line, at most 512.
REQ-003 Parameter HS_START, default 528; first dot of hsync.
REQ-004 Parameter HS_END, default 592; first dot after hsync.
REQ-005 Parameter FILL_LEN, default 512; words written per line fill, 1..512.
REQ-006 dotclk_i  in  1  dot clock; the only clock.
REQ-007 rst_ni  in  1  asynchronous, active-low reset.
REQ-008 line_en_i  in  1  1 if the current line is a displayed (vertically active) line.
REQ-009 ack_i  in  1  fetcher accepts the pending fill request.
REQ-010 wr_stb_i  in  1  fetcher writes one word to the fill bank at w_adr_o this cycle.
REQ-011 clr_i  in  1  clears the sticky underrun flag.
REQ-012 scanline_en_o  out  1  feeder enable; high during active dots.
REQ-013 hsync_o  out  1  horizontal sync, active-high.
REQ-014 line_start_o  out  1  one-cycle pulse on hcount wrap.
REQ-015 req_o  out  1  fill request to fetcher.
REQ-016 abort_o  out  1  one-cycle pulse when an incomplete fill is cancelled.
REQ-017 w_adr_o  out  9  line buffer write address.
REQ-018 w_bank_o  out  1  bank being filled.
REQ-019 r_bank_o  out  1  bank being displayed; always equals ~w_bank_o.
REQ-020 underrun_o  out  1  sticky underrun flag.

Function
REQ-021 hcount SHALL count 0..H_TOTAL-1 and wrap to 0; the wrap cycle is hcount==H_TOTAL-1 ("swap event").
REQ-022 All outputs SHALL be registered.
REQ-023 scanline_en_o SHALL be high exactly on the cycles after which hcount is 0..H_ACTIVE-1, i.e. for H_ACTIVE consecutive cycles per line.
REQ-024 hsync_o SHALL be high for hcount in [HS_START, HS_END).
REQ-025 line_start_o SHALL pulse on the cycle following each swap event.
REQ-026 The fill FSM SHALL have states IDLE, REQ, FILL and DONE.
REQ-027 In REQ, req_o SHALL be high; ack_i SHALL move the FSM to FILL, with w_adr_o=0.
REQ-028 In FILL, each wr_stb_i SHALL increment w_adr_o by 1.
REQ-029 The FILL_LEN-th strobe SHALL move the FSM to DONE.
REQ-030 wr_stb_i outside FILL SHALL be ignored.
REQ-031 At a swap event with the FSM in DONE, including a final strobe on the same cycle, both banks SHALL toggle and the FSM SHALL enter REQ if line_en_i is high, else IDLE.
REQ-032 At a swap event with the FSM in REQ or FILL and line_en_i high, the banks SHALL NOT toggle.
REQ-033 In the case of REQ-032, underrun_o SHALL set, abort_o SHALL pulse, and the FSM SHALL re-enter REQ with w_adr_o=0.
REQ-034 At a swap event with line_en_i low, the FSM SHALL go to IDLE, the banks SHALL not toggle, and no underrun SHALL be flagged; abort_o SHALL pulse if the FSM was in REQ or FILL.
REQ-035 At a swap event in IDLE with line_en_i high, the FSM SHALL enter REQ without toggling the banks.
REQ-036 underrun_o SHALL clear on clr_i; if a set and clr_i coincide, the set SHALL win.
REQ-037 ack_i SHALL be ignored outside REQ.
REQ-038 req_o SHALL drop the cycle after ack_i is accepted.

Reset
REQ-039 Asserting rst_ni low SHALL immediately force: hcount=0, scanline_en_o=0, hsync_o=0, line_start_o=0, req_o=0, abort_o=0, w_adr_o=0, w_bank_o=1, r_bank_o=0, underrun_o=0, FSM=IDLE.
REQ-040 Reset mid-fill SHALL drop req_o with no abort_o pulse.
REQ-041 After reset release, the first fill request SHALL occur at the first swap event with line_en_i high.

Structure
REQ-042 Package cgia_pkg SHALL hold the fill-state typedef and default timing constants (H_TOTAL, H_ACTIVE, HS_START, HS_END, FILL_LEN).
REQ-043 Sub-module htimer SHALL contain the hcount counter and generate scanline_en, hsync and the swap event; linebuf_sched SHALL hold the fill FSM and bank logic.

Verification (H_TOTAL=16, H_ACTIVE=8, HS_START=10, HS_END=12, FILL_LEN=8)
REQ-044 Free run, line_en_i=1, no fetcher -> scanline_en_o high 8 of every 16 cycles; hsync_o high 2 cycles; underrun_o set at the 2nd swap event; abort_o pulses once per line.
REQ-045 ack_i on the first req_o, then 8 strobes before the swap -> w_adr_o steps 0..7; banks toggle to w_bank_o=0/r_bank_o=1; req_o reasserts.
REQ-046 8th strobe on the swap cycle -> banks toggle; no underrun.
REQ-047 Only 5 strobes by the swap -> banks unchanged; underrun_o=1; w_adr_o=0; FSM in REQ; clr_i -> underrun_o=0.
REQ-048 rst_ni low at w_adr_o=3 -> all outputs at reset values at once; no abort_o pulse.
REQ-049 line_en_i low at a swap during FILL -> abort_o pulses; FSM IDLE; underrun_o stays 0.
